// File: rtl/cabac_ctx_init_ctrl_pkg.sv
// Shared definitions for the CABAC context-init sequencer: FSM encoding,
// ROM word layout and the clip bounds used by the init arithmetic.
package cabac_ctx_init_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ROM_WORD_WD = 16;
  localparam int M_MSB = 15;
  localparam int M_LSB = 8;
  localparam int N_MSB = 7;
  localparam int N_LSB = 0;

  localparam int CTX_W = 7;

  localparam logic signed [6:0] QP_MIN  = 7'sd0;
  localparam logic signed [6:0] QP_MAX  = 7'sd51;
  localparam logic signed [9:0] PRE_MIN = 10'sd1;
  localparam logic signed [9:0] PRE_MAX = 10'sd126;

  // SliceQpY arrives signed; the init tables are only defined for 0..51.
  function automatic logic [5:0] clip_qp(input logic signed [6:0] qp);
    logic signed [6:0] c;
    c = qp;
    if (qp < QP_MIN)
      c = QP_MIN;
    else if (qp > QP_MAX)
      c = QP_MAX;
    return c[5:0];
  endfunction

endpackage

// File: rtl/cabac_ctx_init_calc.sv
// Combinational mapping of one init word (m, n) at a given QP to the packed
// context {valMps, pStateIdx}.
module cabac_ctx_init_calc
  import cabac_ctx_init_ctrl_pkg::*;
(
  input  logic signed [7:0] m,
  input  logic signed [7:0] n,
  input  logic [5:0]        qpc,
  output logic [CTX_W-1:0]  ctx
);

  logic signed [13:0] m_ext;
  logic signed [13:0] qp_ext;
  logic signed [13:0] prod;
  logic signed [9:0]  shifted;
  logic signed [9:0]  t;
  logic signed [9:0]  pre_full;
  logic [6:0]         pre;
  logic               val_mps;
  logic [5:0]         p_state;

  always_comb begin
    m_ext   = {{6{m[7]}}, m};
    qp_ext  = {8'd0, qpc};
    prod    = m_ext * qp_ext;
    // Arithmetic shift floors toward minus infinity; the result always fits 10 bits.
    shifted = $signed(10'(prod >>> 4));
    t       = shifted + $signed({{2{n[7]}}, n});

    pre_full = t;
    if (t < PRE_MIN)
      pre_full = PRE_MIN;
    else if (t > PRE_MAX)
      pre_full = PRE_MAX;
    pre = 7'(pre_full);

    val_mps = (pre > 7'd63);
    p_state = val_mps ? 6'(pre - 7'd64) : 6'(7'd63 - pre);
    ctx     = {val_mps, p_state};
  end

endmodule

// File: rtl/cabac_ctx_init_ctrl.sv
// Slice-start sequencer: reads every ROM address once, derives the initial
// context state for all banks and writes it to the context RAM.
module cabac_ctx_init_ctrl
  import cabac_ctx_init_ctrl_pkg::*;
#(
  parameter int ROM_NUM = 4,
  parameter int ADDR_WD = 6,
  parameter int CTX_WD  = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic signed [6:0]           slice_qp_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        rom_r_en_o,
  output logic [ADDR_WD-1:0]          rom_r_addr_o,
  input  logic [ROM_NUM*16-1:0]       rom_r_data_i,
  output logic                        ctx_w_en_o,
  output logic [ADDR_WD-1:0]          ctx_w_addr_o,
  output logic [ROM_NUM*CTX_WD-1:0]   ctx_w_data_o
);

  localparam logic [ADDR_WD-1:0] ADDR_LAST = '1;

  state_t                      state;
  logic [5:0]                  qpc;
  logic                        drain_cnt;
  logic                        rd_valid;
  logic [ADDR_WD-1:0]          rd_addr;
  logic [ROM_NUM*CTX_WD-1:0]   calc_bus;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      qpc          <= '0;
      drain_cnt    <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      rom_r_en_o   <= 1'b0;
      rom_r_addr_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            qpc          <= clip_qp(slice_qp_i);
            state        <= ST_READ;
            busy_o       <= 1'b1;
            rom_r_en_o   <= 1'b1;
            rom_r_addr_o <= '0;
          end
        end
        ST_READ: begin
          if (rom_r_addr_o == ADDR_LAST) begin
            state        <= ST_DRAIN;
            rom_r_en_o   <= 1'b0;
            rom_r_addr_o <= '0;
            drain_cnt    <= 1'b0;
          end else begin
            rom_r_addr_o <= rom_r_addr_o + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Two idle cycles let the last ROM word reach the write stage.
          if (drain_cnt) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROM_NUM; gi++) begin : g_calc
      cabac_ctx_init_calc u_calc (
        .m   (rom_r_data_i[ROM_WORD_WD*gi+M_LSB +: (M_MSB-M_LSB+1)]),
        .n   (rom_r_data_i[ROM_WORD_WD*gi+N_LSB +: (N_MSB-N_LSB+1)]),
        .qpc (qpc),
        .ctx (calc_bus[CTX_WD*gi +: CTX_WD])
      );
    end
  endgenerate

  // ROM data is X when not read, so the data register only loads behind a valid read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid     <= 1'b0;
      rd_addr      <= '0;
      ctx_w_en_o   <= 1'b0;
      ctx_w_addr_o <= '0;
      ctx_w_data_o <= '0;
    end else begin
      rd_valid     <= rom_r_en_o;
      rd_addr      <= rom_r_addr_o;
      ctx_w_en_o   <= rd_valid;
      ctx_w_addr_o <= rd_addr;
      if (rd_valid)
        ctx_w_data_o <= calc_bus;
    end
  end

endmodule

// File: doc/cabac_ctx_init_ctrl.md
Name: cabac_ctx_init_ctrl

Overview:
- Sequences the CABAC context-init ROM banks (64 x 16-bit each; word = {m[7:0], n[7:0]}, both signed) at slice start.
- Derives the HEVC initial context state (pStateIdx, valMps) for every entry of every bank.
- Writes the results, one address per cycle, into the context-state RAM consumed by the CABAC engine.
- Sits between the slice-level control FSM and the per-bank ROMs / context RAM write port.

Parameters:
- ROM_NUM, 4, number of ROM banks read in parallel (same r_addr to all banks).
- ADDR_WD, 6, ROM/context RAM address width; 2^ADDR_WD entries per bank.
- CTX_WD, 7, packed context width {valMps, pStateIdx[5:0]}.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  single-cycle init request; accepted only in IDLE.
- slice_qp_i  in  7  signed SliceQpY, sampled on accepted start_i.
- busy_o  out  1  high from the cycle after accept until done_o inclusive.
- done_o  out  1  single-cycle pulse when the last context write has completed.
- rom_r_en_o  out  1  read enable to all banks.
- rom_r_addr_o  out  ADDR_WD  read address to all banks.
- rom_r_data_i  in  ROM_NUM*16  bank k data at bits [16k+15:16k]; valid the cycle after r_en.
- ctx_w_en_o  out  1  context RAM write enable.
- ctx_w_addr_o  out  ADDR_WD  context RAM address.
- ctx_w_data_o  out  ROM_NUM*CTX_WD  bank k context at [CTX_WD*k+CTX_WD-1:CTX_WD*k].

Behaviour:
- Reset values (rst_n low at a clk edge): all outputs 0; FSM goes to IDLE; address counter and pipeline valids cleared. This applies mid-operation too: the sequence is aborted, no done_o is produced, and the partially written RAM is left as is.
- FSM states and transitions:
  - IDLE: start_i moves to READ. On that edge, latch qpc = Clip3(0, 51, slice_qp_i), treating slice_qp_i as signed (e.g. -6 -> 0, 60 -> 51).
  - READ: rom_r_en_o=1 and rom_r_addr_o = counter 0..2^ADDR_WD-1, one per cycle. After the last address, go to DRAIN.
  - DRAIN: 2 cycles with rom_r_en_o=0, flushing the pipeline. Then go to DONE.
  - DONE: done_o=1 for one cycle, then return to IDLE.
- rom_r_en_o is 0 in every state except READ. rom_r_data_i is never sampled when the matching r_en was 0, because the ROM drives X in that case.
- Pipeline: address issued in cycle t; ROM data valid in t+1, registered through the compute stage; ctx write occurs in cycle t+2.
- Timing: start_i accepted at edge T gives 64 writes in cycles T+3..T+66, addresses strictly ascending, no gaps. done_o is asserted in cycle T+67.
- start_i while busy_o=1 is ignored; it is neither queued nor able to restart the sequence.
- Per-bank arithmetic:
  - m = signed data[15:8], n = signed data[7:0].
  - prod = m*qpc as a signed 14-bit value.
  - t = (prod >>> 4) + n, arithmetic shift (floor), computed in 10-bit signed.
  - pre = Clip3(1, 126, t).
  - valMps = (pre > 63).
  - pStateIdx = valMps ? pre-64 : 63-pre.

Decomposition:
- Shared package / enc_defines: FSM state encodings, the 16-bit ROM word field positions (M_MSB/M_LSB/N_MSB/N_LSB), and QP clip bounds 0/51 and pre-state bounds 1/126.
- One sub-module: cabac_ctx_init_calc. It is combinational, maps (m, n, qpc) to {valMps, pStateIdx}, and is instantiated ROM_NUM times.

Test Plan:
- Word 0x0040, any qp -> m=0, n=64, pre=64 -> ctx {1, 0} (0x40).
- Word 0xec60, qp=26 -> -520>>>4=-33, +96=63 -> ctx {0, 0}. Same word, qp=51 -> -64+96=32 -> ctx {0, 31}.
- Clipping:
  - Upper: word 0x1e70, qp=51 -> 95+112=207 -> pre=126 -> ctx {1, 62}.
  - Lower: word 0xd3f0, qp=51 -> -144-16=-160 -> pre=1 -> ctx {0, 62}.
  - QP: slice_qp_i=-6 gives the same results as 0; slice_qp_i=60 gives the same results as 51.
- Timing: start_i at T -> rom_r_en_o high T+1..T+64, ctx_w_en_o high T+3..T+66 with addr 0..63, done_o only at T+67, busy_o high T+1..T+67. A second start_i at T+10 has no effect.
- Reset: rst_n low at T+20 -> next cycle all outputs 0, IDLE, no done_o. A fresh start_i then runs a full 64-write sequence.
- Back-to-back: start_i in the cycle after done_o -> accepted, second sequence identical to the first with the new qp.
